// File: rtl/riscv_pipeline_types_pkg.sv
// rtl/riscv_pipeline_types_pkg.sv - shared fetch/branch-prediction types and counter encodings
package riscv_pipeline_types_pkg;

  typedef logic [31:0] addr_t;

  localparam logic [1:0] COUNTER_STRONGLY_NOT_TAKEN = 2'b00;
  localparam logic [1:0] COUNTER_WEAKLY_NOT_TAKEN   = 2'b01;
  localparam logic [1:0] COUNTER_WEAKLY_TAKEN       = 2'b10;
  localparam logic [1:0] COUNTER_STRONGLY_TAKEN     = 2'b11;
  localparam logic [1:0] BTB_COUNTER_INIT           = COUNTER_WEAKLY_NOT_TAKEN;

  typedef struct packed {
    logic  predict_taken;
    addr_t predict_target;
    logic  btb_hit;
  } branch_prediction_t;

  typedef struct packed {
    logic  update_valid;
    addr_t update_pc;
    logic  is_branch;
    logic  actual_taken;
    addr_t actual_target;
  } branch_update_t;

  typedef enum logic {
    BTB_IDLE,
    BTB_FLUSH
  } btb_flush_state_e;

endpackage

// File: rtl/riscv_sat_counter2.sv
// rtl/riscv_sat_counter2.sv - combinational next state of a 2-bit saturating counter
module riscv_sat_counter2
  import riscv_pipeline_types_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [1:0] next_o
);

  always_comb begin
    next_o = cnt_i;
    if (inc_i && !dec_i && cnt_i != COUNTER_STRONGLY_TAKEN) begin
      next_o = cnt_i + 2'd1;
    end else if (dec_i && !inc_i && cnt_i != COUNTER_STRONGLY_NOT_TAKEN) begin
      next_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/riscv_btb_predictor.sv
// rtl/riscv_btb_predictor.sv - direct-mapped BTB with 2-bit counters and sequential flush
// Optional lookup/hit/allocation statistics outputs under RISCV_BTB_STATS_EN.
module riscv_btb_predictor
  import riscv_pipeline_types_pkg::*;
#(
  parameter int BTB_ENTRIES = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               fetch_req_i,
  input  addr_t              fetch_pc_i,
  output logic               pred_valid_o,
  output branch_prediction_t pred_o,
  input  branch_update_t     update_i,
  input  logic               flush_i,
  output logic               flush_busy_o
`ifdef RISCV_BTB_STATS_EN
  ,
  output logic [31:0]        stat_lookups_o,
  output logic [31:0]        stat_hits_o,
  output logic [31:0]        stat_allocs_o
`endif
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BTB_ENTRIES - 1);

  logic [BTB_ENTRIES-1:0] r_valid;
  logic [1:0]             r_cnt    [BTB_ENTRIES];
  logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
  addr_t                  r_target [BTB_ENTRIES];

  btb_flush_state_e r_state, w_state_next;
  logic [IDX_W-1:0] r_sweep, w_sweep_next;

  logic [IDX_W-1:0] w_f_idx, w_u_idx;
  logic [TAG_W-1:0] w_f_tag, w_u_tag;
  logic             w_f_hit, w_f_taken, w_u_hit;
  logic             w_upd_en, w_alloc, w_train, w_evict;
  logic [1:0]       w_cnt_next;
  addr_t            w_f_target;
  logic             w_unused_bits;

  assign w_unused_bits = ^{fetch_pc_i[1:0], update_i.update_pc[1:0]};

  assign w_f_idx    = fetch_pc_i[IDX_W+1:2];
  assign w_f_tag    = fetch_pc_i[31:IDX_W+2];
  // Table contents are treated as invalid for the whole sweep, not just swept entries.
  assign w_f_hit    = (r_state == BTB_IDLE) && r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_f_taken  = w_f_hit && r_cnt[w_f_idx][1];
  assign w_f_target = w_f_taken ? r_target[w_f_idx] : fetch_pc_i + 32'd4;

  assign w_u_idx  = update_i.update_pc[IDX_W+1:2];
  assign w_u_tag  = update_i.update_pc[31:IDX_W+2];
  assign w_u_hit  = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_upd_en = update_i.update_valid && (r_state == BTB_IDLE) && !flush_i;
  assign w_alloc  = w_upd_en && update_i.is_branch && !w_u_hit && update_i.actual_taken;
  assign w_train  = w_upd_en && update_i.is_branch && w_u_hit;
  assign w_evict  = w_upd_en && !update_i.is_branch && w_u_hit;

  riscv_sat_counter2 u_sat_counter (
    .cnt_i  (r_cnt[w_u_idx]),
    .inc_i  (update_i.actual_taken),
    .dec_i  (!update_i.actual_taken),
    .next_o (w_cnt_next)
  );

  always_comb begin
    w_state_next = r_state;
    w_sweep_next = r_sweep;
    case (r_state)
      BTB_IDLE: begin
        if (flush_i) begin
          w_state_next = BTB_FLUSH;
          w_sweep_next = '0;
        end
      end
      BTB_FLUSH: begin
        if (flush_i) begin
          w_sweep_next = '0;
        end else if (r_sweep == LAST_IDX) begin
          w_state_next = BTB_IDLE;
          w_sweep_next = '0;
        end else begin
          w_sweep_next = r_sweep + 1'b1;
        end
      end
      default: begin
        w_state_next = BTB_IDLE;
        w_sweep_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= BTB_IDLE;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_next;
      r_sweep <= w_sweep_next;
    end
  end

  assign flush_busy_o = (r_state == BTB_FLUSH);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_cnt[i] <= BTB_COUNTER_INIT;
      end
    end else if (r_state == BTB_FLUSH) begin
      r_valid[r_sweep] <= 1'b0;
      r_cnt[r_sweep]   <= BTB_COUNTER_INIT;
    end else begin
      if (w_alloc) begin
        r_valid[w_u_idx] <= 1'b1;
        r_cnt[w_u_idx]   <= COUNTER_WEAKLY_TAKEN;
      end
      if (w_train) begin
        r_cnt[w_u_idx] <= w_cnt_next;
      end
      if (w_evict) begin
        r_valid[w_u_idx] <= 1'b0;
      end
    end
  end

  // Tags and targets are qualified by r_valid, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (w_alloc) begin
      r_tag[w_u_idx]    <= w_u_tag;
      r_target[w_u_idx] <= update_i.actual_target;
    end else if (w_train && update_i.actual_taken) begin
      r_target[w_u_idx] <= update_i.actual_target;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pred_valid_o <= 1'b0;
      pred_o       <= '0;
    end else begin
      pred_valid_o <= fetch_req_i;
      if (fetch_req_i) begin
        pred_o.btb_hit        <= w_f_hit;
        pred_o.predict_taken  <= w_f_taken;
        pred_o.predict_target <= w_f_target;
      end
    end
  end

`ifdef RISCV_BTB_STATS_EN
  logic [31:0] r_stat_lookups, r_stat_hits, r_stat_allocs;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat_lookups <= '0;
      r_stat_hits    <= '0;
      r_stat_allocs  <= '0;
    end else begin
      if (fetch_req_i)            r_stat_lookups <= r_stat_lookups + 32'd1;
      if (fetch_req_i && w_f_hit) r_stat_hits    <= r_stat_hits + 32'd1;
      if (w_alloc)                r_stat_allocs  <= r_stat_allocs + 32'd1;
    end
  end

  assign stat_lookups_o = r_stat_lookups;
  assign stat_hits_o    = r_stat_hits;
  assign stat_allocs_o  = r_stat_allocs;
`endif

endmodule

// File: tb/tb_riscv_btb_predictor.sv
// tb/tb_riscv_btb_predictor.sv - self-checking bench: directed table, flush/reset sequences, random vs model
module tb_riscv_btb_predictor;
  import riscv_pipeline_types_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               fetch_req_i;
  addr_t              fetch_pc_i;
  logic               pred_valid_o;
  branch_prediction_t pred_o;
  branch_update_t     update_i;
  logic               flush_i;
  logic               flush_busy_o;
`ifdef RISCV_BTB_STATS_EN
  logic [31:0] stat_lookups_o, stat_hits_o, stat_allocs_o;
`endif

  riscv_btb_predictor #(.BTB_ENTRIES(64)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fetch_req_i  (fetch_req_i),
    .fetch_pc_i   (fetch_pc_i),
    .pred_valid_o (pred_valid_o),
    .pred_o       (pred_o),
    .update_i     (update_i),
    .flush_i      (flush_i),
    .flush_busy_o (flush_busy_o)
`ifdef RISCV_BTB_STATS_EN
    ,
    .stat_lookups_o (stat_lookups_o),
    .stat_hits_o    (stat_hits_o),
    .stat_allocs_o  (stat_allocs_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: an array of entries plus a countdown of remaining flush cycles.
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_cnt   [64];
  int          m_flush_left;

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic        br;
    logic        tk;
    logic [31:0] utgt;
    logic        ev;
    logic        eh;
    logic        et;
    logic [31:0] etgt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(logic req, logic [31:0] pc, logic uv, logic [31:0] upc, logic br,
                             logic tk, logic [31:0] utgt, logic ev, logic eh, logic et,
                             logic [31:0] etgt);
    vec_t v;
    v.req = req; v.pc = pc; v.uv = uv; v.upc = upc; v.br = br; v.tk = tk; v.utgt = utgt;
    v.ev = ev; v.eh = eh; v.et = et; v.etgt = etgt;
    return v;
  endfunction

  function automatic branch_update_t U(logic v, logic [31:0] pc, logic br, logic tk, logic [31:0] tgt);
    branch_update_t u;
    u.update_valid = v; u.update_pc = pc; u.is_branch = br; u.actual_taken = tk; u.actual_target = tgt;
    return u;
  endfunction

  function automatic int midx(logic [31:0] pc);
    return int'((pc >> 2) & 32'd63);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
    m_flush_left = 0;
  endtask

  task automatic model_update(branch_update_t u);
    int  i;
    bit  hit;
    i   = midx(u.update_pc);
    hit = m_valid[i] && (m_tag[i] == u.update_pc[31:8]);
    if (u.is_branch) begin
      if (hit) begin
        if (u.actual_taken) begin
          m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          m_tgt[i] = u.actual_target;
        end else begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else if (u.actual_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = u.update_pc[31:8];
        m_tgt[i]   = u.actual_target;
        m_cnt[i]   = 2;
      end
    end else if (hit) begin
      m_valid[i] = 1'b0;
    end
  endtask

  // One clock: drive, predict from pre-edge model state, advance model, compare.
  task automatic cycle(logic req, logic [31:0] pc, branch_update_t upd, logic fl);
    int          i;
    logic        e_hit, e_taken;
    logic [31:0] e_tgt;
    fetch_req_i = req;
    fetch_pc_i  = pc;
    update_i    = upd;
    flush_i     = fl;
    i       = midx(pc);
    e_hit   = (m_flush_left == 0) && m_valid[i] && (m_tag[i] == pc[31:8]);
    e_taken = e_hit && (m_cnt[i] >= 2);
    e_tgt   = e_taken ? m_tgt[i] : pc + 32'd4;
    @(posedge clk_i);
    #1;
    if (m_flush_left > 0) begin
      if (fl) m_flush_left = 64;
      else begin
        m_flush_left--;
        if (m_flush_left == 0) model_reset();
      end
    end else if (fl) begin
      m_flush_left = 64;
    end else if (upd.update_valid) begin
      model_update(upd);
    end
    check("pred_valid", 32'(pred_valid_o), 32'(req));
    if (req) begin
      check("btb_hit", 32'(pred_o.btb_hit), 32'(e_hit));
      check("predict_taken", 32'(pred_o.predict_taken), 32'(e_taken));
      check("predict_target", pred_o.predict_target, e_tgt);
    end
    check("flush_busy", 32'(flush_busy_o), 32'(m_flush_left > 0));
    fetch_req_i = 1'b0;
    update_i    = '0;
    flush_i     = 1'b0;
  endtask

  task automatic lookup_expect(string name, logic [31:0] pc, logic eh, logic et, logic [31:0] etgt);
    cycle(1'b1, pc, '0, 1'b0);
    check({name, "_hit"}, 32'(pred_o.btb_hit), 32'(eh));
    check({name, "_taken"}, 32'(pred_o.predict_taken), 32'(et));
    check({name, "_target"}, pred_o.predict_target, etgt);
  endtask

  task automatic alloc(logic [31:0] pc, logic [31:0] tgt);
    cycle(1'b0, 32'h0, U(1'b1, pc, 1'b1, 1'b1, tgt), 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    int k;

    rst_i       = 1'b1;
    fetch_req_i = 1'b0;
    fetch_pc_i  = '0;
    update_i    = '0;
    flush_i     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_pred_valid", 32'(pred_valid_o), 32'd0);
    check("reset_pred_o", pred_o.predict_target, 32'd0);
    check("reset_flush_busy", 32'(flush_busy_o), 32'd0);
    rst_i = 1'b0;

    // Directed table: expected outputs are the prediction registered at that step's edge.
    tbl.push_back(V(1, 32'h104, 0, 0,        0, 0, 0,        1, 0, 0, 32'h108));
    tbl.push_back(V(1, 32'h104, 1, 32'h104,  1, 1, 32'h200,  1, 0, 0, 32'h108));
    tbl.push_back(V(1, 32'h104, 0, 0,        0, 0, 0,        1, 1, 1, 32'h200));
    for (int i = 0; i < 3; i++)
      tbl.push_back(V(0, 0, 1, 32'h104, 1, 1, 32'h200, 0, 0, 0, 0));
    tbl.push_back(V(1, 32'h104, 0, 0,        0, 0, 0,        1, 1, 1, 32'h200));
    for (int i = 0; i < 3; i++)
      tbl.push_back(V(0, 0, 1, 32'h104, 1, 0, 32'h999, 0, 0, 0, 0));
    tbl.push_back(V(1, 32'h104, 0, 0,        0, 0, 0,        1, 1, 0, 32'h108));
    tbl.push_back(V(0, 0,       1, 32'h104,  1, 0, 32'h999,  0, 0, 0, 0));
    tbl.push_back(V(0, 0,       1, 32'h104,  1, 1, 32'h200,  0, 0, 0, 0));
    tbl.push_back(V(1, 32'h104, 0, 0,        0, 0, 0,        1, 1, 0, 32'h108));
    tbl.push_back(V(0, 0,       1, 32'h104,  1, 1, 32'h200,  0, 0, 0, 0));
    tbl.push_back(V(1, 32'h104, 0, 0,        0, 0, 0,        1, 1, 1, 32'h200));
    tbl.push_back(V(1, 32'h204, 0, 0,        0, 0, 0,        1, 0, 0, 32'h208));
    tbl.push_back(V(0, 0,       1, 32'h204,  1, 0, 32'h888,  0, 0, 0, 0));
    tbl.push_back(V(1, 32'h104, 0, 0,        0, 0, 0,        1, 1, 1, 32'h200));
    tbl.push_back(V(0, 0,       1, 32'h104,  0, 0, 0,        0, 0, 0, 0));
    tbl.push_back(V(1, 32'h104, 0, 0,        0, 0, 0,        1, 0, 0, 32'h108));
    tbl.push_back(V(1, 32'hFFFF_FFFC, 0, 0,  0, 0, 0,        1, 0, 0, 32'h0));
    tbl.push_back(V(0, 0,       1, 32'h300,  1, 1, 32'h400,  0, 0, 0, 0));
    tbl.push_back(V(0, 0,       1, 32'h300,  1, 1, 32'h500,  0, 0, 0, 0));
    tbl.push_back(V(1, 32'h300, 0, 0,        0, 0, 0,        1, 1, 1, 32'h500));
    tbl.push_back(V(0, 0,       1, 32'h300,  1, 0, 32'h777,  0, 0, 0, 0));
    tbl.push_back(V(1, 32'h300, 0, 0,        0, 0, 0,        1, 1, 1, 32'h500));

    foreach (tbl[n]) begin
      cycle(tbl[n].req, tbl[n].pc, U(tbl[n].uv, tbl[n].upc, tbl[n].br, tbl[n].tk, tbl[n].utgt), 1'b0);
      check($sformatf("tbl%0d_valid", n), 32'(pred_valid_o), 32'(tbl[n].ev));
      if (tbl[n].ev) begin
        check($sformatf("tbl%0d_hit", n), 32'(pred_o.btb_hit), 32'(tbl[n].eh));
        check($sformatf("tbl%0d_taken", n), 32'(pred_o.predict_taken), 32'(tbl[n].et));
        check($sformatf("tbl%0d_target", n), pred_o.predict_target, tbl[n].etgt);
      end
    end

    // Flush: populate idx 0, 1, 63; single-cycle flush_i; lookups and updates during sweep.
    alloc(32'h104, 32'h200);
    alloc(32'hFC, 32'h1000);
    lookup_expect("pre_flush_idx63", 32'hFC, 1, 1, 32'h1000);
    lookup_expect("pre_flush_idx0", 32'h300, 1, 1, 32'h500);
    cycle(1'b0, 32'h0, '0, 1'b1);
    busy_cnt = 0;
    k = 0;
    while (flush_busy_o && k < 200) begin
      busy_cnt++;
      cycle(1'b1, (k % 3 == 0) ? 32'h104 : (k % 3 == 1) ? 32'hFC : 32'h300,
            U(1'b1, 32'h500, 1'b1, 1'b1, 32'h600), 1'b0);
      check("sweep_lookup_hit", 32'(pred_o.btb_hit), 32'd0);
      k++;
    end
    check("flush_busy_cycles", busy_cnt, 64);
    lookup_expect("post_flush_idx1", 32'h104, 0, 0, 32'h108);
    lookup_expect("post_flush_idx63", 32'hFC, 0, 0, 32'h100);
    lookup_expect("post_flush_idx0", 32'h300, 0, 0, 32'h304);
    lookup_expect("post_flush_dropped_upd", 32'h500, 0, 0, 32'h504);

    // Flush re-asserted during the 30th busy cycle restarts the sweep.
    alloc(32'h104, 32'h200);
    cycle(1'b0, 32'h0, '0, 1'b1);
    busy_cnt = 0;
    k = 0;
    while (flush_busy_o && k < 300) begin
      busy_cnt++;
      cycle(1'b0, 32'h0, '0, busy_cnt == 30);
      k++;
    end
    check("flush_restart_cycles", busy_cnt, 94);
    lookup_expect("post_restart_idx1", 32'h104, 0, 0, 32'h108);

    // Asynchronous reset during the sweep.
    alloc(32'h104, 32'h200);
    alloc(32'h3FC, 32'h2000);
    cycle(1'b0, 32'h0, '0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 32'h0, '0, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_reset_busy", 32'(flush_busy_o), 32'd0);
    check("async_reset_valid", 32'(pred_valid_o), 32'd0);
`ifdef RISCV_BTB_STATS_EN
    check("stat_lookups_reset", stat_lookups_o, 32'd0);
    check("stat_hits_reset", stat_hits_o, 32'd0);
    check("stat_allocs_reset", stat_allocs_o, 32'd0);
`endif
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    lookup_expect("post_reset_idx1", 32'h104, 0, 0, 32'h108);
    lookup_expect("post_reset_idx63", 32'h3FC, 0, 0, 32'h400);

    // Randomized traffic against the model over a small working set to force hits and aliasing.
    for (int n = 0; n < 800; n++) begin
      logic [31:0] rpc, upc;
      rpc = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2);
      upc = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2);
      cycle(1'($urandom_range(0, 1)), rpc,
            U(1'($urandom_range(0, 1)), upc, ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 9) < 6), $urandom & 32'hFFFF_FFFC),
            ($urandom_range(0, 149) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_btb_predictor.md
Name: riscv_btb_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating counters.
- Responds to fetch-stage lookups with a registered branch_prediction_t.
- Consumes branch_update_t from the execute/resolve stage.
- Sits beside the fetch PC mux. Owns all prediction state; a sequential flush FSM invalidates the table.

Parameters:
- BTB_ENTRIES, 64, number of entries; power of two, ≥2
- IDX_W, $clog2(BTB_ENTRIES), index width (derived localparam)
- TAG_W, 30-IDX_W, tag width, PC[31:IDX_W+2] (derived localparam)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- fetch_req_i  in  1  lookup request for fetch_pc_i
- fetch_pc_i  in  addr_t  PC to predict
- pred_valid_o  out  1  pred_o valid; one-cycle pulse following fetch_req_i
- pred_o  out  branch_prediction_t  {predict_taken, predict_target, btb_hit}
- update_i  in  branch_update_t  resolved-branch feedback; acted on when update_valid=1
- flush_i  in  1  request full table invalidation
- flush_busy_o  out  1  flush sweep in progress

Behaviour:
- Clock and reset: one clock (clk_i); reset (rst_i) is asynchronous and active-high.
- Reset values:
  - All valid bits 0; all counters BTB_COUNTER_INIT (01); tags/targets don't-care.
  - pred_valid_o=0, pred_o='0, flush_busy_o=0, FSM=IDLE, sweep index=0.
- Indexing: idx=PC[IDX_W+1:2]; tag=PC[31:IDX_W+2]. Hit = valid[idx] && tag[idx]==tag.
- Lookup:
  - Latency 1. pred_* registered at the edge where fetch_req_i=1; pred_valid_o=0 the cycle after no request.
  - btb_hit=hit.
  - predict_taken = hit && counter[idx][1].
  - predict_target = target[idx] if predict_taken, else fetch_pc_i+4. 32-bit wrap: 0xFFFF_FFFC → 0x0000_0000.
- Update, acted on when update_valid=1 and FSM=IDLE; u = update_pc:
  - is_branch=1, hit: counter saturating +1 if actual_taken, else −1. Bounds COUNTER_STRONGLY_NOT_TAKEN and COUNTER_STRONGLY_TAKEN. If actual_taken, target ← actual_target.
  - is_branch=1, miss, actual_taken=1: allocate (overwrite). valid=1, tag, target=actual_target, counter=COUNTER_WEAKLY_TAKEN.
  - is_branch=1, miss, actual_taken=0: no change.
  - is_branch=0, hit: valid[idx] ← 0 (aliased non-branch eviction).
- Same-cycle lookup and update to the same index: lookup sees pre-update state (read-before-write). The update is visible to a lookup in the next cycle.
- Flush FSM, states IDLE and FLUSH:
  - IDLE → FLUSH on flush_i. Sweep index=0, flush_busy_o=1 from the next cycle.
  - FLUSH: each cycle valid[sweep]←0 and counter[sweep]←BTB_COUNTER_INIT, sweep++.
  - At sweep==BTB_ENTRIES−1, clear that entry and go → IDLE. flush_busy_o drops. Duration is exactly BTB_ENTRIES cycles.
  - flush_i asserted during FLUSH: sweep restarts at 0.
  - During FLUSH, lookups still respond (pred_valid_o as normal) with btb_hit=0, predict_taken=0, target=pc+4. update_i is dropped.
  - flush_i and update_i in the same IDLE cycle: the flush wins and the update is dropped.
- Reset mid-flush: asynchronous return to IDLE with the full reset state.

Optional Feature:
- Macro: RISCV_BTB_STATS_EN.
- Defined: adds outputs stat_lookups_o[31:0], stat_hits_o[31:0], stat_allocs_o[31:0].
  - Incremented on fetch_req_i, on a registered btb_hit=1, and on an allocation, respectively.
  - Wrap at 2^32; reset to 0.
  - Not cleared by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- In riscv_pipeline_types_pkg (existing): branch_prediction_t, branch_update_t, and all COUNTER_* / BTB_COUNTER_INIT constants.
- New in the same package: btb_flush_state_e {BTB_IDLE, BTB_FLUSH}.
- Sub-module: riscv_sat_counter2. Pure combinational next-state for the 2-bit saturating counter (inc/dec in, next out), reused by future BHT/PHT blocks.

Test Plan:
- Reset, then lookup PC 0x104 → pred_valid_o=1 next cycle; btb_hit=0, predict_taken=0, target 0x108.
- Allocation:
  - Update {pc 0x104, taken, target 0x200, is_branch}.
  - Then lookup 0x104 → hit=1, taken=1, target 0x200.
  - Same-cycle lookup of 0x104 with that update → hit=0.
- Counter saturation:
  - After allocation (10): 3 taken updates → counter 11; lookup predicts taken.
  - Then 3 not-taken updates → 00; lookup shows hit=1, taken=0, target 0x108.
  - One more not-taken update → stays 00.
- Aliasing and eviction:
  - PC 0x204 (same idx 1, tag 2) after 0x104 allocation → miss.
  - Not-taken update at 0x204 → 0x104 entry unchanged.
  - Update {0x104, is_branch=0} → 0x104 now misses.
- Flush:
  - Populate idx 0,1,63; assert flush_i one cycle → flush_busy_o high exactly 64 cycles.
  - Lookups during the sweep show hit=0; updates during the sweep are dropped.
  - After the sweep, all three entries miss.
  - Reassert flush_i at sweep 30 → total busy 30+64 cycles.
- Reset at sweep 10 → flush_busy_o=0 immediately (async), all entries miss. With RISCV_BTB_STATS_EN, all stats are 0.
